uart_byte_rx: RTL and testbench
===============================

# uart_byte_rx

Receives the 8N1 serial command stream from the host UART pin and delivers each byte as a one-cycle-validated parallel word. Sits directly upstream of the display-mode selector: `data_rx`/`done_rx` feed its mode register (0x01 = original, 0x02 = gray, 0x03 = sobel). Runs in the pixel-clock domain, so no CDC exists between it and the selector. The asynchronous `rx` pin is synchronised internally.

## Interface
Parameters:
- `CLK_FREQ`, default 25_000_000: pclk frequency in Hz.
- `BAUD`, default 115200: serial bit rate.
- `BIT_CNT`, default CLK_FREQ/BAUD (integer division, 217 at defaults): clocks per bit. Local, not overridable.
- `HALF_CNT`, default BIT_CNT/2: clocks to mid-start-bit. Local.

Ports:
- `pclk`  in  1  system/pixel clock. Single clock domain.
- `rst`  in  1  asynchronous, active-high reset.
- `rx`  in  1  raw serial line. Idle high. Asynchronous to pclk.
- `data_rx`  out  8  last correctly framed byte. Holds until the next good byte.
- `done_rx`  out  1  one-cycle pulse; `data_rx` is valid in the same cycle.
- `frame_err`  out  1  one-cycle pulse when the stop bit is sampled low.

## Operation
- Synchroniser: 2-FF chain `rx` -> `rx_s`; both flops reset to 1. A 3rd flop holds `rx_s` delayed by one cycle for falling-edge detection.
- Counters:
  - `clk_cnt`: width $clog2(BIT_CNT), cleared on every state change.
  - `bit_idx`: 3 bits.
  - Shift register `sh`: 8 bits. LSB received first.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: a falling edge on `rx_s` -> START, `clk_cnt`=0.
  - START: when `clk_cnt`==HALF_CNT-1, sample `rx_s`.
    - 0 -> DATA, `bit_idx`=0.
    - 1 -> IDLE (glitch rejected, no output).
  - DATA: when `clk_cnt`==BIT_CNT-1, sample `rx_s` into `sh[bit_idx]`.
    - `bit_idx`==7 -> STOP.
    - Otherwise `bit_idx`+1.
  - STOP: when `clk_cnt`==BIT_CNT-1, sample `rx_s`.
    - 1 -> register `data_rx`<=`sh`, pulse `done_rx`, go to IDLE.
    - 0 -> pulse `frame_err`, go to WAIT_HIGH. `data_rx` is unchanged.
  - WAIT_HIGH: stay until `rx_s`==1, then go to IDLE. This prevents a break condition from being decoded as 0x00 bytes.
- Edge rules:
  - IDLE only arms on a 1->0 transition.
  - A line already low out of reset or out of WAIT_HIGH does not start a frame.
- No parity. Exactly one stop bit is checked. Extra stop time is simply idle.
- `done_rx` and `frame_err` are never high in the same cycle.

## Timing
- Reset values:
  - `data_rx`=8'h00, `done_rx`=0, `frame_err`=0.
  - State=IDLE, all counters 0, synchroniser=1.
- Let t0 be the first cycle with `rx_s`==0 after a high cycle; this is 2 cycles after the pin falls.
  - Start sample at t0+HALF_CNT.
  - Data bit k sampled at t0+HALF_CNT+(k+1)·BIT_CNT.
  - Stop sampled at t0+HALF_CNT+9·BIT_CNT.
  - `done_rx`/`frame_err` high in the cycle after the stop sample. `data_rx` changes in that same cycle.
- Back-to-back frames: IDLE is re-entered half a bit before the stop bit ends, so a start edge immediately after the stop bit is caught with zero gap.
- Reset mid-frame: all state clears asynchronously. A partially received byte is discarded and never produces `done_rx`. After reset is released, the next 1->0 edge starts a new frame.
- BIT_CNT rounding error must stay below 2% of the bit period. The integration owner checks this for the chosen CLK_FREQ/BAUD pair; the block does not check it.

## Structure
- Shared package `uart_pkg`:
  - FSM state encoding (3-bit localparams for IDLE, START, DATA, STOP, WAIT_HIGH).
  - The command byte constants MODE_RGB=8'h01, MODE_GRAY=8'h02, MODE_SOBEL=8'h03, used by both this block and the mode selector.
- One natural sub-module: `sync_2ff` (generic 1-bit double-flop synchroniser, reset value as a parameter). Everything else stays flat in `uart_byte_rx`.

## Test plan
Run with CLK_FREQ=1_600_000 and BAUD=100_000, giving BIT_CNT=16 and HALF_CNT=8.
- Send 0x02 with a 1-bit stop -> exactly one `done_rx` pulse, `data_rx`=0x02, pulse at t0+8+144+1, `frame_err` never high.
- Glitch: hold `rx` low for 3 cycles, then high -> FSM returns to IDLE, no `done_rx`, no `frame_err`, `data_rx` holds its prior value.
- Send 0x55 with stop bit=0, then keep `rx` low for 40 cycles, then high, then send 0x03 -> one `frame_err` pulse; `data_rx` stays at the old value through the error; no bytes decoded while low; then `done_rx` with `data_rx`=0x03.
- Back-to-back 0x01, 0xFF, 0x00 with zero inter-frame gap -> three `done_rx` pulses exactly 160 cycles apart, values in order.
- Assert `rst` during bit 4 of 0xA5, release, then send 0x81 -> no pulse for 0xA5, `data_rx`=0x00 after reset, then `data_rx`=0x81 with one `done_rx`.
- Baud skew: send 0x3C at ±2% bit period -> `data_rx`=0x3C, no `frame_err`.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the serial command path: the receiver FSM state
// encoding and the display-mode command bytes that the mode selector decodes.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

package uart_pkg;

    // Receiver FSM state encoding.
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_STOP      = 3'd3;
    localparam logic [2:0] ST_WAIT_HIGH = 3'd4;

    typedef enum logic [2:0] {
        IDLE      = ST_IDLE,
        START     = ST_START,
        DATA      = ST_DATA,
        STOP      = ST_STOP,
        WAIT_HIGH = ST_WAIT_HIGH
    } rx_state_t;

    // Display-mode command bytes sent by the host.
    localparam logic [7:0] MODE_RGB   = 8'h01;
    localparam logic [7:0] MODE_GRAY  = 8'h02;
    localparam logic [7:0] MODE_SOBEL = 8'h03;

    // True when a received byte is one of the recognised mode commands.
    function automatic logic is_mode_cmd(input logic [7:0] b);
        return (b == MODE_RGB) || (b == MODE_GRAY) || (b == MODE_SOBEL);
    endfunction

endpackage : uart_pkg

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Generic 1-bit double-flop synchroniser for an asynchronous input.
// Ports:
//   pclk  in  destination clock
//   rst   in  asynchronous, active-high reset
//   d     in  asynchronous input
//   q     out synchronised output (two pclk cycles of latency)
// Parameter RESET_VAL sets the value both flops take in reset.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic pclk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: sequential state uses non-blocking assignments so both flops
    // sample their inputs from before the edge; blocking here would collapse
    // the chain into a single flop.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule : sync_2ff

// File: rtl/uart_byte_rx.sv
// -----------------------------------------------------------------------------
// uart_byte_rx
// 8N1 UART receiver. Delivers each correctly framed byte as a parallel word
// with a one-cycle done pulse; a low stop bit raises a one-cycle frame error
// and the receiver then waits for the line to return high before re-arming.
// Ports:
//   pclk       in   system/pixel clock
//   rst        in   asynchronous, active-high reset
//   rx         in   raw serial line, idle high, asynchronous to pclk
//   data_rx    out  last correctly framed byte, held until the next one
//   done_rx    out  one-cycle pulse, data_rx valid in the same cycle
//   frame_err  out  one-cycle pulse when the stop bit is sampled low
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module uart_byte_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 25_000_000,
    parameter int BAUD     = 115200
) (
    input  logic       pclk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data_rx,
    output logic       done_rx,
    output logic       frame_err
);

    localparam int BIT_CNT  = CLK_FREQ / BAUD;
    localparam int HALF_CNT = BIT_CNT / 2;
    localparam int CNT_W    = (BIT_CNT > 1) ? $clog2(BIT_CNT) : 1;

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CNT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CNT - 1);

    logic             rx_s;
    logic             rx_d;
    logic             rx_fall;
    rx_state_t        state;
    logic [CNT_W-1:0] clk_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       sh;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .pclk (pclk),
        .rst  (rst),
        .d    (rx),
        .q    (rx_s)
    );

    // A start is only recognised on a genuine 1->0 transition, so a line that
    // is already low after reset or after a break never launches a frame.
    assign rx_fall = rx_d & ~rx_s;

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            rx_d      <= 1'b1;
            state     <= IDLE;
            clk_cnt   <= '0;
            bit_idx   <= '0;
            sh        <= '0;
            data_rx   <= '0;
            done_rx   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_d      <= rx_s;
            done_rx   <= 1'b0;
            frame_err <= 1'b0;

            case (state)
                IDLE: begin
                    clk_cnt <= '0;
                    if (rx_fall) begin
                        state <= START;
                    end
                end

                // Re-check the line at mid start bit to reject short glitches.
                START: begin
                    if (clk_cnt == HALF_LAST) begin
                        clk_cnt <= '0;
                        if (!rx_s) begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end

                // Sampling point sits mid-bit because START ended mid-bit.
                DATA: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt     <= '0;
                        sh[bit_idx] <= rx_s;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end

                // Leaving mid stop bit lets IDLE catch a start edge that
                // follows the stop bit with no gap.
                STOP: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt <= '0;
                        if (rx_s) begin
                            data_rx <= sh;
                            done_rx <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= WAIT_HIGH;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end

                // Hold off during a break so it is not decoded as 0x00 bytes.
                WAIT_HIGH: begin
                    clk_cnt <= '0;
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    clk_cnt <= '0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule : uart_byte_rx

// File: tb/tb_uart_byte_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_byte_rx
// Directed bench for uart_byte_rx at BIT_CNT=16, HALF_CNT=8. Expected bytes
// are queued when a frame is driven and compared when done_rx pulses.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_uart_byte_rx;

    localparam real CLK_NS = 10.0;
    localparam real BIT_NS = 160.0;   // 16 clocks per bit

    logic       pclk = 1'b0;
    logic       rst  = 1'b1;
    logic       rx   = 1'b1;
    logic [7:0] data_rx;
    logic       done_rx;
    logic       frame_err;

    uart_byte_rx #(
        .CLK_FREQ (1_600_000),
        .BAUD     (100_000)
    ) dut (
        .pclk      (pclk),
        .rst       (rst),
        .rx        (rx),
        .data_rx   (data_rx),
        .done_rx   (done_rx),
        .frame_err (frame_err)
    );

    always #5 pclk = ~pclk;

    int         cyc        = 0;
    int         total      = 0;
    int         passed     = 0;
    int         fails      = 0;
    int         done_count = 0;
    int         ferr_count = 0;
    int         last_done_cyc = 0;
    int         last_ferr_cyc = 0;
    int         fall_cyc   = 0;
    logic [7:0] exp_q[$];
    int         done_cyc_q[$];

    always @(posedge pclk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every done pulse pops one expected byte.
    always @(negedge pclk) begin
        if (done_rx || frame_err) begin
            check("done_ferr_exclusive", {31'b0, done_rx & frame_err}, 32'd0);
        end
        if (done_rx) begin
            done_count++;
            last_done_cyc = cyc;
            done_cyc_q.push_back(cyc);
            check("done_expected", {31'b0, exp_q.size() > 0}, 32'd1);
            if (exp_q.size() > 0) begin
                check("data_rx", {24'b0, data_rx}, {24'b0, exp_q.pop_front()});
            end
        end
        if (frame_err) begin
            ferr_count++;
            last_ferr_cyc = cyc;
        end
    end

    task automatic idle(input int n);
        #(n * CLK_NS);
    endtask

    // Drives start, 8 data bits LSB first, and the stop bit. Starts and ends
    // at negedge-aligned times when bit_ns is a whole number of clocks.
    task automatic send_byte(input logic [7:0] b, input real bit_ns, input logic stop_bit);
        rx = 1'b0;
        fall_cyc = cyc;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            #(bit_ns);
        end
        rx = stop_bit;
        #(bit_ns);
    endtask

    int d0;
    int fall0;

    initial begin
        // Reset state.
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge pclk);
        check("rst_data", {24'b0, data_rx}, 32'h00);
        check("rst_done", {31'b0, done_rx}, 32'd0);
        check("rst_ferr", {31'b0, frame_err}, 32'd0);
        rst = 1'b0;
        idle(5);

        // Single byte 0x02: timing of the done pulse relative to the pin fall.
        exp_q.push_back(8'h02);
        send_byte(8'h02, BIT_NS, 1'b1);
        fall0 = fall_cyc;
        idle(20);
        check("b02_count", done_count, 1);
        check("b02_latency", last_done_cyc - fall0, 155);
        check("b02_no_ferr", ferr_count, 0);
        check("b02_hold", {24'b0, data_rx}, 32'h02);

        // Short glitch is rejected at the mid-start re-check.
        rx = 1'b0;
        idle(3);
        rx = 1'b1;
        idle(200);
        check("glitch_no_done", done_count, 1);
        check("glitch_no_ferr", ferr_count, 0);
        check("glitch_hold", {24'b0, data_rx}, 32'h02);

        // Bad stop bit followed by a held-low break, then a good byte.
        send_byte(8'h55, BIT_NS, 1'b0);
        fall0 = fall_cyc;
        idle(40);
        check("ferr_count", ferr_count, 1);
        check("ferr_latency", last_ferr_cyc - fall0, 155);
        check("ferr_data_hold", {24'b0, data_rx}, 32'h02);
        check("break_no_done", done_count, 1);
        rx = 1'b1;
        idle(30);
        check("break_no_extra_ferr", ferr_count, 1);
        exp_q.push_back(8'h03);
        send_byte(8'h03, BIT_NS, 1'b1);
        idle(20);
        check("after_break_count", done_count, 2);
        check("after_break_data", {24'b0, data_rx}, 32'h03);

        // Back-to-back frames with no idle time between them.
        done_cyc_q.delete();
        exp_q.push_back(8'h01);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h00);
        send_byte(8'h01, BIT_NS, 1'b1);
        send_byte(8'hFF, BIT_NS, 1'b1);
        send_byte(8'h00, BIT_NS, 1'b1);
        idle(20);
        check("b2b_count", done_count, 5);
        check("b2b_pulses", done_cyc_q.size(), 3);
        if (done_cyc_q.size() >= 3) begin
            check("b2b_gap_1", done_cyc_q[1] - done_cyc_q[0], 160);
            check("b2b_gap_2", done_cyc_q[2] - done_cyc_q[1], 160);
        end
        check("b2b_last_data", {24'b0, data_rx}, 32'h00);

        // Reset asserted during data bit 4 of 0xA5; that byte is discarded.
        fork
            send_byte(8'hA5, BIT_NS, 1'b1);
            begin
                idle(88);
                rst = 1'b1;
                #1;
                check("midrst_data", {24'b0, data_rx}, 32'h00);
                check("midrst_done", {31'b0, done_rx}, 32'd0);
            end
        join
        idle(10);
        rst = 1'b0;
        idle(10);
        check("midrst_no_done", done_count, 5);
        check("midrst_data_after", {24'b0, data_rx}, 32'h00);
        exp_q.push_back(8'h81);
        send_byte(8'h81, BIT_NS, 1'b1);
        idle(20);
        check("post_rst_count", done_count, 6);
        check("post_rst_data", {24'b0, data_rx}, 32'h81);

        // Baud skew of +/-2%.
        exp_q.push_back(8'h3C);
        send_byte(8'h3C, BIT_NS * 1.02, 1'b1);
        idle(20);
        @(negedge pclk);
        exp_q.push_back(8'h3C);
        send_byte(8'h3C, BIT_NS * 0.98, 1'b1);
        idle(20);
        check("skew_count", done_count, 8);
        check("skew_data", {24'b0, data_rx}, 32'h3C);
        check("final_ferr", ferr_count, 1);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_uart_byte_rx
